// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared widths and types for the 3x3 convolution datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = 17;
    localparam int ROW_W  = 19;
    localparam int SUM_W  = 21;
    localparam int TAPS   = 9;
    localparam int ROWS   = 3;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ROW_W-1:0]  row_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

endpackage
`default_nettype wire

// File: rtl/conv3x3_mac_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_mac_if
//  Description : Window/coefficient input and result output handshake bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface conv3x3_mac_if;
    import conv_pkg::*;

    logic  in_valid;
    logic  in_ready;
    pix_t  p0, p1, p2, p3, p4, p5, p6, p7, p8;
    coef_t k0, k1, k2, k3, k4, k5, k6, k7, k8;
    logic  out_valid;
    logic  out_ready;
    pix_t  out_pix;
    sum_t  out_sum;

    // Upstream source plus downstream sink, seen from outside the datapath
    modport master (
        output in_valid,
        input  in_ready,
        output p0, p1, p2, p3, p4, p5, p6, p7, p8,
        output k0, k1, k2, k3, k4, k5, k6, k7, k8,
        input  out_valid,
        output out_ready,
        input  out_pix,
        input  out_sum
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  p0, p1, p2, p3, p4, p5, p6, p7, p8,
        input  k0, k1, k2, k3, k4, k5, k6, k7, k8,
        output out_valid,
        input  out_ready,
        output out_pix,
        output out_sum
    );

endinterface
`default_nettype wire

// File: rtl/conv_sat.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sat
//  Description : Normalising shift, optional rectify and 0..255 clamp.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_sat
    import conv_pkg::*;
#(
    parameter int SHIFT  = 0,
    parameter bit ABS_EN = 1'b0
) (
    input  wire sum_t i_sum,
    output pix_t      o_pix
);

    sum_t w_shifted;
    sum_t w_mag;

    assign w_shifted = i_sum >>> SHIFT;

    // Magnitude of the most negative sum still fits in SUM_W bits
    if (ABS_EN) begin : g_abs
        assign w_mag = w_shifted[SUM_W-1] ? -w_shifted : w_shifted;
    end else begin : g_noAbs
        assign w_mag = w_shifted;
    end

    always_comb begin
        o_pix = '0;
        if (w_mag[SUM_W-1]) begin
            o_pix = '0;
        end else if (w_mag > sum_t'(255)) begin
            o_pix = 8'hFF;
        end else begin
            o_pix = w_mag[PIX_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv3x3_mac.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_mac
//  Description : Three-stage pipelined 3x3 multiply-accumulate with clamp.
//  Revision    : 1.0  initial release
// ============================================================================
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int SHIFT  = 0,
    parameter bit ABS_EN = 1'b0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    conv3x3_mac_if.slave  bus
);

    pix_t  w_pix   [TAPS];
    coef_t w_coef  [TAPS];
    prod_t w_prod  [TAPS];
    row_t  w_row   [ROWS];
    sum_t  w_sum;
    pix_t  w_satPix;
    logic  w_en;

    prod_t r_prod  [TAPS];
    row_t  r_row   [ROWS];
    logic  r_v1;
    logic  r_v2;
    logic  r_outValid;
    pix_t  r_outPix;
    sum_t  r_outSum;

    assign w_pix[0]  = bus.p0;
    assign w_pix[1]  = bus.p1;
    assign w_pix[2]  = bus.p2;
    assign w_pix[3]  = bus.p3;
    assign w_pix[4]  = bus.p4;
    assign w_pix[5]  = bus.p5;
    assign w_pix[6]  = bus.p6;
    assign w_pix[7]  = bus.p7;
    assign w_pix[8]  = bus.p8;

    assign w_coef[0] = bus.k0;
    assign w_coef[1] = bus.k1;
    assign w_coef[2] = bus.k2;
    assign w_coef[3] = bus.k3;
    assign w_coef[4] = bus.k4;
    assign w_coef[5] = bus.k5;
    assign w_coef[6] = bus.k6;
    assign w_coef[7] = bus.k7;
    assign w_coef[8] = bus.k8;

    // A single enable stalls every stage together, so the pipe never loses a slot
    assign w_en         = !r_outValid || bus.out_ready;
    assign bus.in_ready = w_en;

    for (genvar i = 0; i < TAPS; i++) begin : g_mult
        assign w_prod[i] = prod_t'(signed'({1'b0, w_pix[i]})) * prod_t'(w_coef[i]);
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign w_row[r] = row_t'(r_prod[3*r]) + row_t'(r_prod[3*r+1]) + row_t'(r_prod[3*r+2]);
    end

    assign w_sum = sum_t'(r_row[0]) + sum_t'(r_row[1]) + sum_t'(r_row[2]);

    conv_sat #(
        .SHIFT  (SHIFT),
        .ABS_EN (ABS_EN)
    ) u_sat (
        .i_sum (w_sum),
        .o_pix (w_satPix)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_outValid <= 1'b0;
            r_outPix   <= '0;
            r_outSum   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_prod[i] <= '0;
            end
            for (int r = 0; r < ROWS; r++) begin
                r_row[r] <= '0;
            end
        end else if (w_en) begin
            r_v1       <= bus.in_valid;
            r_v2       <= r_v1;
            r_outValid <= r_v2;
            r_outPix   <= w_satPix;
            r_outSum   <= w_sum;
            for (int i = 0; i < TAPS; i++) begin
                r_prod[i] <= w_prod[i];
            end
            for (int r = 0; r < ROWS; r++) begin
                r_row[r] <= w_row[r];
            end
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.out_pix   = r_outPix;
    assign bus.out_sum   = r_outSum;

endmodule
`default_nettype wire
